// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through a single full-subtractor cell. Result and borrow are registered.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa, sb;
  logic             br;
  logic [CW-1:0]    cnt;

  logic ai, bi, d, br_next;

  assign ai      = sa[0];
  assign bi      = sb[0];
  assign d       = ai ^ bi ^ br;
  assign br_next = (~ai & bi) | (~ai & br) | (bi & br);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      sa     <= '0;
      sb     <= '0;
      br     <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          // start is deliberately not looked at here
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          br     <= br_next;
          diff   <= {d, diff[WIDTH-1:1]};
          borrow <= br_next;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH = 8): vector table plus
// hand-written sequences for ignored start, mid-run reset and back-to-back.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done, borrow;
  logic [W-1:0] diff;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         br;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive start for exactly one accepting edge, then scramble the operands.
  task automatic accept(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_; bin = tbin;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tbin, input logic [W-1:0] ed, input logic eb);
    int busy_cnt = 0;
    int n = 0;
    accept(ta, tb_, tbin);
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      n++;
    end
    chk({name, " done_seen"}, 32'(done), 32'd1);
    chk({name, " busy_cycles"}, 32'(busy_cnt), 32'(W));
    chk({name, " diff"}, 32'(diff), 32'(ed));
    chk({name, " borrow"}, 32'(borrow), 32'(eb));
    @(posedge clk); #1;
    chk({name, " done_one_cycle"}, 32'(done), 32'd0);
    chk({name, " diff_hold"}, 32'(diff), 32'(ed));
  endtask

  initial begin
    vecs[0]  = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
    vecs[1]  = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
    vecs[2]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[3]  = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[4]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[6]  = '{8'h00, 8'h01, 1'b1, 8'hFE, 1'b1};
    vecs[7]  = '{8'h01, 8'h00, 1'b0, 8'h01, 1'b0};
    vecs[8]  = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0};
    vecs[9]  = '{8'h01, 8'h01, 1'b0, 8'h00, 1'b0};
    vecs[10] = '{8'h01, 8'h01, 1'b1, 8'hFF, 1'b1};
    vecs[11] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #3;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset diff", 32'(diff), 32'd0);
    chk("reset borrow", 32'(borrow), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].br);

    // Start re-pulsed mid-run must be ignored.
    begin
      int dcnt = 0;
      int dat = -1;
      logic [W-1:0] dd = '0;
      logic db = 1'b0;
      accept(8'h5A, 8'h3C, 1'b0);
      for (int n = 1; n <= 14; n++) begin
        if (n == 3) begin start = 1'b1; a = 8'hAA; b = 8'h11; bin = 1'b0; end
        @(posedge clk); #1;
        start = 1'b0;
        if (done) begin dcnt++; dat = n; dd = diff; db = borrow; end
      end
      chk("ignore done_count", 32'(dcnt), 32'd1);
      chk("ignore done_time", 32'(dat), 32'(W));
      chk("ignore diff", 32'(dd), 32'h1E);
      chk("ignore borrow", 32'(db), 32'd0);
    end

    // Reset in the middle of a run aborts it.
    begin
      int dcnt = 0;
      accept(8'h5A, 8'h3C, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort done", 32'(done), 32'd0);
      chk("abort diff", 32'(diff), 32'd0);
      chk("abort borrow", 32'(borrow), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      for (int n = 0; n < 12; n++) begin
        @(posedge clk); #1;
        if (done) dcnt++;
      end
      chk("abort no_done", 32'(dcnt), 32'd0);
      run_op("after_reset", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);
    end

    // start held across DONE: back-to-back operations.
    begin
      int dcnt = 0;
      int t1 = 0, t2 = 0;
      logic [W-1:0] d1 = '0, d2 = '0;
      logic b1 = 1'b0, b2 = 1'b0;
      @(negedge clk);
      start = 1'b1; a = 8'h20; b = 8'h30; bin = 1'b0;
      @(posedge clk); #1;
      a = 8'h30; b = 8'h20;
      for (int n = 1; n <= 25; n++) begin
        @(posedge clk); #1;
        if (done) begin
          if (dcnt == 0) begin t1 = n; d1 = diff; b1 = borrow; end
          else begin t2 = n; d2 = diff; b2 = borrow; end
          dcnt++;
        end else if (dcnt == 1) begin
          start = 1'b0;
        end
      end
      start = 1'b0;
      chk("b2b done_count", 32'(dcnt), 32'd2);
      chk("b2b spacing", 32'(t2 - t1), 32'd9);
      chk("b2b diff1", 32'(d1), 32'hF0);
      chk("b2b borrow1", 32'(b1), 32'd1);
      chk("b2b diff2", 32'(d2), 32'h10);
      chk("b2b borrow2", 32'(b2), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
